// File: rtl/ethernet_rx_ctrl.sv
// Ethernet receive controller. Sits behind the ethernet_rx byte receiver:
// checks the preamble and SFD, filters on destination address, and forwards
// the payload through a one-byte hold register so that the final byte can be
// flagged with out_last once the idle timeout marks the end of the frame.
module ethernet_rx_ctrl #(
  parameter logic [47:0] MAC_ADDR     = 48'h02_00_00_00_00_01,
  parameter int          IDLE_TIMEOUT = 16,
  parameter int          MAX_LEN      = 1518
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        promisc,
  output logic        rx_start,
  input  logic        frame_ready,
  input  logic [7:0]  frame,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        out_error,
  output logic        frame_done,
  output logic        frame_drop,
  output logic [10:0] frame_len
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DEST,
    S_PAYLOAD,
    S_DROP
  } state_t;

  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;
  localparam logic [7:0]  CNT_LAST = 8'(IDLE_TIMEOUT - 1);
  localparam logic [10:0] LEN_MAX  = 11'(MAX_LEN);

  state_t      state_q, state_d;
  logic [7:0]  idle_cnt_q, idle_cnt_d;
  logic [10:0] len_q, len_d;
  logic [2:0]  dest_idx_q, dest_idx_d;
  logic        addr_match_q, addr_match_d;
  logic        addr_bcast_q, addr_bcast_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic        drop_sent_q, drop_sent_d;
  logic        rx_start_q, rx_start_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic        out_error_q, out_error_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_drop_q, frame_drop_d;
  logic [10:0] frame_len_q, frame_len_d;

  logic [7:0]  mac_byte;
  logic        byte_match;
  logic        byte_bcast;
  logic        dest_ok;
  logic        last_dest;
  logic        len_full;
  logic        expire;

  // Station address byte expected at the current destination position (MSB first).
  always_comb begin
    case (dest_idx_q)
      3'd0:    mac_byte = MAC_ADDR[47:40];
      3'd1:    mac_byte = MAC_ADDR[39:32];
      3'd2:    mac_byte = MAC_ADDR[31:24];
      3'd3:    mac_byte = MAC_ADDR[23:16];
      3'd4:    mac_byte = MAC_ADDR[15:8];
      default: mac_byte = MAC_ADDR[7:0];
    endcase
  end

  // Running address comparison and frame-end / length-limit detection.
  always_comb begin
    byte_match = addr_match_q && (frame == mac_byte);
    byte_bcast = addr_bcast_q && (frame == 8'hFF);
    dest_ok    = byte_match || byte_bcast || promisc;
    last_dest  = (dest_idx_q == 3'd5);
    len_full   = (len_q == LEN_MAX);
    // A byte arriving on the expiry cycle keeps the frame alive.
    expire     = (state_q != S_IDLE) && !frame_ready && (idle_cnt_q == CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable && frame_ready) state_d = (frame == PRE_BYTE) ? S_PREAMBLE : S_DROP;
      end
      S_PREAMBLE: begin
        if (frame_ready) begin
          if (frame == SFD_BYTE)      state_d = S_DEST;
          else if (frame != PRE_BYTE) state_d = S_DROP;
        end else if (expire) begin
          state_d = S_IDLE;
        end
      end
      S_DEST: begin
        if (frame_ready) begin
          if (last_dest) state_d = dest_ok ? S_PAYLOAD : S_DROP;
        end else if (expire) begin
          state_d = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (frame_ready) begin
          if (len_full) state_d = S_DROP;
        end else if (expire) begin
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (expire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    idle_cnt_d   = (state_q == S_IDLE || frame_ready || expire) ? 8'd0 : idle_cnt_q + 8'd1;
    len_d        = len_q;
    dest_idx_d   = dest_idx_q;
    addr_match_d = addr_match_q;
    addr_bcast_d = addr_bcast_q;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    drop_sent_d  = drop_sent_q;
    rx_start_d   = enable;
    out_valid_d  = 1'b0;
    out_data_d   = 8'h00;
    out_last_d   = 1'b0;
    out_error_d  = 1'b0;
    frame_done_d = 1'b0;
    frame_drop_d = 1'b0;
    frame_len_d  = frame_len_q;
    case (state_q)
      S_IDLE: begin
        hold_vld_d  = 1'b0;
        drop_sent_d = 1'b0;
      end
      S_PREAMBLE: begin
        if (frame_ready && frame == SFD_BYTE) begin
          len_d        = 11'd0;
          dest_idx_d   = 3'd0;
          addr_match_d = 1'b1;
          addr_bcast_d = 1'b1;
        end else if (expire) begin
          frame_drop_d = 1'b1;
        end
      end
      S_DEST: begin
        if (frame_ready) begin
          len_d        = len_q + 11'd1;
          dest_idx_d   = dest_idx_q + 3'd1;
          addr_match_d = byte_match;
          addr_bcast_d = byte_bcast;
        end else if (expire) begin
          frame_drop_d = 1'b1;
        end
      end
      S_PAYLOAD: begin
        if (frame_ready) begin
          out_valid_d = hold_vld_q;
          out_data_d  = hold_vld_q ? hold_q : 8'h00;
          if (len_full) begin
            // Byte MAX_LEN+1 arrived: close the frame as truncated.
            out_last_d   = hold_vld_q;
            out_error_d  = hold_vld_q;
            frame_drop_d = 1'b1;
            drop_sent_d  = 1'b1;
            hold_vld_d   = 1'b0;
          end else begin
            hold_d     = frame;
            hold_vld_d = 1'b1;
            len_d      = len_q + 11'd1;
          end
        end else if (expire) begin
          if (hold_vld_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = hold_q;
            out_last_d   = 1'b1;
            frame_done_d = 1'b1;
            frame_len_d  = len_q;
            hold_vld_d   = 1'b0;
          end else begin
            frame_drop_d = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (expire) begin
          frame_drop_d = !drop_sent_q;
          drop_sent_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt_q   <= 8'd0;
      len_q        <= 11'd0;
      dest_idx_q   <= 3'd0;
      addr_match_q <= 1'b0;
      addr_bcast_q <= 1'b0;
      hold_q       <= 8'h00;
      hold_vld_q   <= 1'b0;
      drop_sent_q  <= 1'b0;
      rx_start_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      out_last_q   <= 1'b0;
      out_error_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_drop_q <= 1'b0;
      frame_len_q  <= 11'd0;
    end else begin
      idle_cnt_q   <= idle_cnt_d;
      len_q        <= len_d;
      dest_idx_q   <= dest_idx_d;
      addr_match_q <= addr_match_d;
      addr_bcast_q <= addr_bcast_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      drop_sent_q  <= drop_sent_d;
      rx_start_q   <= rx_start_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_error_q  <= out_error_d;
      frame_done_q <= frame_done_d;
      frame_drop_q <= frame_drop_d;
      frame_len_q  <= frame_len_d;
    end
  end

  assign rx_start   = rx_start_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign out_error  = out_error_q;
  assign frame_done = frame_done_q;
  assign frame_drop = frame_drop_q;
  assign frame_len  = frame_len_q;

endmodule

// File: tb/tb_ethernet_rx_ctrl.sv
// Testbench for ethernet_rx_ctrl: a frame-level model predicts the ordered
// stream of forwarded bytes and done/drop pulses (with their timing relative
// to the last received byte); a monitor compares every output cycle.
module tb_ethernet_rx_ctrl;

  localparam logic [47:0] MAC  = 48'h02_00_00_00_00_01;
  localparam int          T    = 16;
  localparam int          MAXL = 1518;

  localparam int K_NONE = 0;
  localparam int K_DATA = 1;
  localparam int K_DONE = 2;
  localparam int K_DROP = 3;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       last;
    logic       err;
    logic       tmo;
    int         len;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       err;
  } ob_t;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        promisc;
  logic        rx_start;
  logic        frame_ready;
  logic [7:0]  frame;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_error;
  logic        frame_done;
  logic        frame_drop;
  logic [10:0] frame_len;

  int  n_total = 0;
  int  n_bad   = 0;
  int  n_done  = 0;
  int  n_drop  = 0;
  ev_t exp_q[$];
  ob_t obs_q[$];

  ethernet_rx_ctrl #(
    .MAC_ADDR    (MAC),
    .IDLE_TIMEOUT(T),
    .MAX_LEN     (MAXL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .promisc    (promisc),
    .rx_start   (rx_start),
    .frame_ready(frame_ready),
    .frame      (frame),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_error  (out_error),
    .frame_done (frame_done),
    .frame_drop (frame_drop),
    .frame_len  (frame_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_ev(input int k, input logic [7:0] d, input logic l,
                                  input logic er, input logic tmo, input int len);
    ev_t e;
    e.kind = k; e.data = d; e.last = l; e.err = er; e.tmo = tmo; e.len = len;
    exp_q.push_back(e);
  endfunction

  function automatic int head_kind();
    return (exp_q.size() != 0) ? exp_q[0].kind : K_NONE;
  endfunction

  // Frame-level model: what a received byte sequence must produce.
  function automatic void model_frame(input bq_t f, input logic prom);
    int          i;
    bq_t         rest;
    logic [47:0] d;
    if (f.size() == 0) return;
    if (f[0] != 8'h55) begin push_ev(K_DROP, 0, 0, 0, 1, 0); return; end
    i = 0;
    while (i < f.size() && f[i] == 8'h55) i++;
    if (i >= f.size() || f[i] != 8'hD5) begin push_ev(K_DROP, 0, 0, 0, 1, 0); return; end
    for (int k = i + 1; k < f.size(); k++) rest.push_back(f[k]);
    if (rest.size() < 6) begin push_ev(K_DROP, 0, 0, 0, 1, 0); return; end
    d = '0;
    for (int k = 0; k < 6; k++) d = {d[39:0], rest[k]};
    if (!(prom || d == MAC || d == 48'hFFFF_FFFF_FFFF)) begin
      push_ev(K_DROP, 0, 0, 0, 1, 0);
      return;
    end
    if (rest.size() > MAXL) begin
      for (int k = 6; k < MAXL; k++)
        push_ev(K_DATA, rest[k], k == MAXL - 1, k == MAXL - 1, 0, 0);
      push_ev(K_DROP, 0, 0, 0, 0, 0);
      return;
    end
    if (rest.size() == 6) begin push_ev(K_DROP, 0, 0, 0, 1, 0); return; end
    for (int k = 6; k < rest.size(); k++)
      push_ev(K_DATA, rest[k], k == rest.size() - 1, 0, k == rest.size() - 1, 0);
    push_ev(K_DONE, 0, 0, 0, 1, rest.size());
  endfunction

  function automatic bq_t mk_frame(input logic [47:0] d, input bq_t pl);
    bq_t f;
    for (int i = 0; i < 7; i++) f.push_back(8'h55);
    f.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) f.push_back(d[8*i +: 8]);
    foreach (pl[i]) f.push_back(pl[i]);
    return f;
  endfunction

  task automatic send_frame(input bq_t f, input int gap);
    for (int i = 0; i < f.size(); i++) begin
      @(negedge clk);
      frame_ready = 1'b1;
      frame       = f[i];
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        frame_ready = 1'b0;
      end
    end
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  task automatic settle();
    repeat (2 * T + 6) @(negedge clk);
    check("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_frame(input bq_t f, input int gap);
    if (enable) model_frame(f, promisc);
    send_frame(f, gap);
    settle();
  endtask

  // Monitor: compares every output cycle against the model's event stream.
  initial begin
    int   cyc;
    int   last_fr;
    logic prev_v;
    ev_t  e;
    cyc = 0; last_fr = 0; prev_v = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (!reset) begin
        check("rst_outs", {rx_start, out_valid, out_data, out_last, out_error,
                           frame_done, frame_drop, frame_len}, 32'd0);
        prev_v = 1'b0;
        continue;
      end
      if (frame_ready) last_fr = cyc;
      check("rx_start", rx_start, enable);
      if (!out_valid) check("flags_idle", {out_last, out_error}, 2'b00);
      if (out_valid && prev_v) check("b2b_valid", frame_ready, 1'b1);
      prev_v = out_valid;
      if (out_valid) begin
        check("evt_kind", K_DATA, head_kind());
        if (head_kind() == K_DATA) begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", out_last, e.last);
          check("out_error", out_error, e.err);
          check("data_gap", cyc - last_fr, e.tmo ? T : 0);
        end
        obs_q.push_back('{out_data, out_last, out_error});
      end
      if (frame_done) begin
        n_done++;
        check("evt_kind", K_DONE, head_kind());
        if (head_kind() == K_DONE) begin
          e = exp_q.pop_front();
          check("frame_len", frame_len, e.len);
          check("done_gap", cyc - last_fr, T);
        end
      end
      if (frame_drop) begin
        n_drop++;
        check("evt_kind", K_DROP, head_kind());
        if (head_kind() == K_DROP) begin
          e = exp_q.pop_front();
          check("drop_gap", cyc - last_fr, e.tmo ? T : 0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Directed scenarios.
  initial begin
    bq_t pl;
    bq_t f;
    int  s0, d0, p0;

    reset = 1'b0; enable = 1'b0; promisc = 1'b0; frame_ready = 1'b0; frame = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_len", frame_len, 11'd0);
    check("rst_valid", out_valid, 1'b0);
    reset = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);

    // Accepted unicast frame.
    pl.delete(); pl.push_back(8'hA0); pl.push_back(8'hA1); pl.push_back(8'hA2);
    s0 = obs_q.size(); d0 = n_done;
    run_frame(mk_frame(MAC, pl), 1);
    check("A_cnt", obs_q.size() - s0, 3);
    if (obs_q.size() >= s0 + 3) begin
      check("A_b0", obs_q[s0].data, 8'hA0);
      check("A_b1", obs_q[s0+1].data, 8'hA1);
      check("A_b2", obs_q[s0+2].data, 8'hA2);
      check("A_last", {obs_q[s0].last, obs_q[s0+1].last, obs_q[s0+2].last}, 3'b001);
    end
    check("A_len", frame_len, 11'd9);
    check("A_done", n_done - d0, 1);

    // Filtered destination, then the same frame promiscuous.
    s0 = obs_q.size(); p0 = n_drop;
    run_frame(mk_frame(48'h02_00_00_00_00_02, pl), 2);
    check("F_novalid", obs_q.size() - s0, 0);
    check("F_drop", n_drop - p0, 1);
    promisc = 1'b1;
    d0 = n_done;
    run_frame(mk_frame(48'h02_00_00_00_00_02, pl), 0);
    check("P_done", n_done - d0, 1);
    promisc = 1'b0;

    // Broadcast, one payload byte.
    pl.delete(); pl.push_back(8'h5A);
    s0 = obs_q.size();
    run_frame(mk_frame(48'hFFFF_FFFF_FFFF, pl), 1);
    check("B_cnt", obs_q.size() - s0, 1);
    if (obs_q.size() > s0) check("B_byte", {obs_q[s0].data, obs_q[s0].last}, {8'h5A, 1'b1});
    check("B_len", frame_len, 11'd7);

    // Bad preamble, then a good frame.
    f.delete(); f.push_back(8'h55); f.push_back(8'h55); f.push_back(8'h33);
    p0 = n_drop; s0 = obs_q.size();
    run_frame(f, 3);
    check("BP_drop", n_drop - p0, 1);
    check("BP_novalid", obs_q.size() - s0, 0);
    pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22);
    d0 = n_done;
    run_frame(mk_frame(MAC, pl), 5);
    check("BP_next", n_done - d0, 1);

    // Destination only (no payload) and truncated destination.
    pl.delete();
    p0 = n_drop;
    run_frame(mk_frame(MAC, pl), 1);
    f = mk_frame(MAC, pl);
    f = f[0:10];
    run_frame(f, 1);
    check("short_drops", n_drop - p0, 2);

    // Oversize frame: MAX_LEN+10 bytes after SFD.
    pl.delete();
    for (int k = 0; k < MAXL + 10 - 6; k++) pl.push_back(8'(k * 7));
    s0 = obs_q.size(); d0 = n_done; p0 = n_drop;
    run_frame(mk_frame(MAC, pl), 0);
    check("OV_cnt", obs_q.size() - s0, MAXL - 6);
    if (obs_q.size() > s0)
      check("OV_tail", {obs_q[obs_q.size()-1].data, obs_q[obs_q.size()-1].last,
                        obs_q[obs_q.size()-1].err}, {8'h51, 1'b1, 1'b1});
    check("OV_drop", n_drop - p0, 1);
    check("OV_nodone", n_done - d0, 0);

    // Exactly MAX_LEN bytes after SFD completes normally.
    pl.delete();
    for (int k = 0; k < MAXL - 6; k++) pl.push_back(8'(k + 3));
    run_frame(mk_frame(MAC, pl), 0);
    check("MX_len", frame_len, 11'd1518);
    if (obs_q.size() > 0) check("MX_noerr", obs_q[obs_q.size()-1].err, 1'b0);

    // Enable dropped mid-frame: frame still completes; later frames ignored.
    pl.delete(); pl.push_back(8'hC0); pl.push_back(8'hC1);
    f = mk_frame(MAC, pl);
    model_frame(f, promisc);
    d0 = n_done;
    fork
      send_frame(f, 1);
      begin repeat (6) @(negedge clk); enable = 1'b0; end
    join
    settle();
    check("EN_done", n_done - d0, 1);
    check("EN_len", frame_len, 11'd8);
    s0 = obs_q.size(); p0 = n_drop;
    run_frame(f, 1);
    check("EN_off_valid", obs_q.size() - s0, 0);
    check("EN_off_drop", n_drop - p0, 0);
    enable = 1'b1;
    repeat (2) @(negedge clk);

    // Reset mid-PAYLOAD: frame discarded silently.
    pl.delete(); pl.push_back(8'h77);
    d0 = n_done; p0 = n_drop;
    send_frame(mk_frame(MAC, pl), 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("RS_valid", {out_valid, frame_done, frame_drop}, 3'b000);
    reset = 1'b1;
    settle();
    check("RS_nodone", n_done - d0, 0);
    check("RS_nodrop", n_drop - p0, 0);
    check("RS_len", frame_len, 11'd0);

    // Recovery after reset.
    pl.delete(); pl.push_back(8'hE0); pl.push_back(8'hE1); pl.push_back(8'hE2); pl.push_back(8'hE3);
    d0 = n_done;
    run_frame(mk_frame(MAC, pl), 2);
    check("RC_done", n_done - d0, 1);
    check("RC_len", frame_len, 11'd10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
